multicycle_alu: RTL
===================

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width; legal values 8, 16, 32, 64.
REQ-002 Derived constant: SHW = log2(WIDTH), the shift-amount width.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 op  input  4  operation select, encoding in REQ-013.
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B; b[SHW-1:0] is the shift amount.
REQ-010 out_valid  output  1  result and flags valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 result  output  WIDTH; zero_flag, negative_flag, carry_flag, overflow_flag  output  1 each; busy  output  1 (high when not in IDLE).

Function
REQ-013 op encoding:
- 0 ADD; 1 SUB; 2 AND; 3 OR; 4 XOR; 5 NOT a
- 6 SLL; 7 SRL; 8 SRA; 9 BITREV a; 10 POPCOUNT a; 11 CLZ a
- 12 MUL: low WIDTH bits of the unsigned product
- 13 MULHU: high WIDTH bits of the unsigned product
- 14 DIVU: unsigned quotient; 15 REMU: unsigned remainder
REQ-014 The FSM has three states: IDLE, BUSY and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; a request is accepted when in_valid && in_ready, and a, b and op are captured into internal registers.
REQ-016 Ops 0-11 go IDLE->DONE; out_valid SHALL be asserted the cycle after acceptance (latency 1).
REQ-017 Ops 12-15 go IDLE->BUSY, then iterate for exactly WIDTH cycles (one bit per cycle: shift-add multiply, restoring divide), then go to DONE; out_valid SHALL be asserted WIDTH+1 cycles after acceptance.
REQ-018 In DONE, result and all flags SHALL be held stable until out_valid && out_ready, and the FSM then goes to IDLE.
REQ-019 A new request cannot be accepted in the same cycle as the result handshake (minimum two cycles between results).
REQ-020 in_valid SHALL be ignored outside IDLE, and the captured operands SHALL NOT change while in BUSY or DONE.
REQ-021 Shifts use amount n = b[SHW-1:0]; SRA replicates a[WIDTH-1].
REQ-022 POPCOUNT and CLZ results are zero-extended; CLZ of 0 = WIDTH.
REQ-023 Divide by zero: quotient = all ones, remainder = a, overflow_flag = 1.
REQ-024 zero_flag = (result == 0); negative_flag = result[WIDTH-1].
REQ-025 carry_flag by op:
- ADD: carry-out of a WIDTH+1-bit sum.
- SUB: borrow, i.e. a < b unsigned.
- SLL with n != 0: a[WIDTH-n].
- SRL/SRA with n != 0: a[n-1].
- MUL: 1 if the product's high half != 0.
- All other cases: 0.
REQ-026 overflow_flag by op:
- ADD: two's-complement signed overflow.
- SUB: two's-complement signed overflow.
- DIVU/REMU: divide by zero.
- All other cases: 0.

Reset
REQ-027 While rst_n = 0, asynchronously: state = IDLE; out_valid = 0; result = 0; all flags = 0; busy = 0; iteration counter = 0.
REQ-028 in_ready SHALL be 1 on the first cycle after rst_n deasserts.
REQ-029 Reset during BUSY or DONE aborts the operation with no result delivered.

Verification
REQ-030 WIDTH=32, ADD 0x7FFFFFFF + 0x1 -> 1 cycle later out_valid=1, result=0x80000000, overflow=1, negative=1, carry=0; SUB 0x0 - 0x1 -> result=0xFFFFFFFF, carry=1.
REQ-031 MUL 0x00010000 * 0x00010000 -> out_valid at cycle 33, result=0, zero=1, carry=1; MULHU with the same operands -> result=0x00000001.
REQ-032 DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 0x5/0x0 -> result=0xFFFFFFFF, overflow=1; REMU 0x5/0x0 -> result=0x5.
REQ-033 Backpressure: hold out_ready=0 for 5 cycles after out_valid -> result and flags stable, in_ready=0, an in_valid pulse is ignored; raise out_ready -> next cycle state IDLE, in_ready=1.
REQ-034 Drop rst_n during cycle 10 of a DIVU -> out_valid=0 and busy=0 immediately; after release, ADD 3+4 -> result=7.
REQ-035 CLZ 0x0 -> 32; POPCOUNT 0xFFFFFFFF -> 32; SLL 0x80000001 by 1 -> 0x00000002, carry=1; repeat with WIDTH=8: CLZ 0x00 -> 8, MUL 0x10*0x10 -> 0x00, carry=1, out_valid at cycle 9.

Source files
------------

// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle logic, shift and count ops plus a
// bit-serial multiply and restoring divide behind valid/ready.
module multicycle_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero_flag,
  output logic             negative_flag,
  output logic             carry_flag,
  output logic             overflow_flag,
  output logic             busy
);
  localparam int SHW = $clog2(WIDTH);
  localparam int PW  = SHW + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_n;

  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, hi_q, lo_q;
  logic [SHW-1:0]   cnt;
  logic             accept, slow, last;

  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign busy      = state != IDLE;
  assign accept    = in_valid && in_ready;
  assign slow      = op[3] && op[2];
  assign last      = cnt == SHW'(WIDTH - 1);

  logic [SHW-1:0]   n;
  logic [WIDTH:0]   sum, dif, shl, shr;
  logic [WIDTH-1:0] rev, f_res;
  logic [PW-1:0]    pop, clz;
  logic             f_c, f_v;

  assign n   = b[SHW-1:0];
  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} - {1'b0, b};
  // The extra bit on each side catches the last bit shifted out.
  assign shl = {1'b0, a} << n;
  assign shr = {a, 1'b0} >> n;

  always_comb begin
    rev = '0;
    pop = '0;
    clz = PW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      rev[i] = a[WIDTH-1-i];
      pop = pop + {{SHW{1'b0}}, a[i]};
      if (a[i]) clz = PW'(WIDTH - 1 - i);
    end
  end

  always_comb begin
    f_res = '0;
    f_c   = 1'b0;
    f_v   = 1'b0;
    unique case (op)
      4'd0: begin
        f_res = sum[WIDTH-1:0];
        f_c   = sum[WIDTH];
        f_v   = (a[WIDTH-1] == b[WIDTH-1]) &&
                (sum[WIDTH-1] != a[WIDTH-1]);
      end
      4'd1: begin
        f_res = dif[WIDTH-1:0];
        f_c   = dif[WIDTH];
        f_v   = (a[WIDTH-1] != b[WIDTH-1]) &&
                (dif[WIDTH-1] != a[WIDTH-1]);
      end
      4'd2: f_res = a & b;
      4'd3: f_res = a | b;
      4'd4: f_res = a ^ b;
      4'd5: f_res = ~a;
      4'd6: begin
        f_res = shl[WIDTH-1:0];
        f_c   = shl[WIDTH];
      end
      4'd7: begin
        f_res = shr[WIDTH:1];
        f_c   = shr[0];
      end
      4'd8: begin
        f_res = $signed(a) >>> n;
        f_c   = shr[0];
      end
      4'd9:  f_res = rev;
      4'd10: f_res = WIDTH'(pop);
      4'd11: f_res = WIDTH'(clz);
      default: ;
    endcase
  end

  logic [WIDTH:0]   msum, rsh, rtry;
  logic             ge;
  logic [WIDTH-1:0] hi_n, lo_n, s_res;

  assign msum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
  assign rsh  = {hi_q, lo_q[WIDTH-1]};
  assign rtry = rsh - {1'b0, b_q};
  assign ge   = rsh >= {1'b0, b_q};

  // hi holds product-high / remainder, lo holds multiplier / quotient.
  always_comb begin
    if (op_q[1]) begin
      hi_n = ge ? rtry[WIDTH-1:0] : rsh[WIDTH-1:0];
      lo_n = {lo_q[WIDTH-2:0], ge};
    end else begin
      hi_n = msum[WIDTH:1];
      lo_n = {msum[0], lo_q[WIDTH-1:1]};
    end
  end

  assign s_res = op_q[0] ? hi_n : lo_n;

  logic [WIDTH-1:0] r_n;
  logic             c_n, v_n, load;

  always_comb begin
    load = 1'b0;
    r_n  = f_res;
    c_n  = f_c;
    v_n  = f_v;
    if (state == BUSY) begin
      load = last;
      r_n  = s_res;
      c_n  = !op_q[1] && !op_q[0] && (hi_n != '0);
      v_n  = op_q[1] && (b_q == '0);
    end else if (accept && !slow) begin
      load = 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (accept) state_n = slow ? BUSY : DONE;
      BUSY:    if (last) state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      hi_q          <= '0;
      lo_q          <= '0;
      cnt           <= '0;
      result        <= '0;
      zero_flag     <= 1'b0;
      negative_flag <= 1'b0;
      carry_flag    <= 1'b0;
      overflow_flag <= 1'b0;
    end else begin
      if (accept) begin
        op_q <= op;
        a_q  <= a;
        b_q  <= b;
        hi_q <= '0;
        lo_q <= op[1] ? a : b;
        cnt  <= '0;
      end else if (state == BUSY) begin
        hi_q <= hi_n;
        lo_q <= lo_n;
        cnt  <= cnt + SHW'(1);
      end
      if (load) begin
        result        <= r_n;
        zero_flag     <= r_n == '0;
        negative_flag <= r_n[WIDTH-1];
        carry_flag    <= c_n;
        overflow_flag <= v_n;
      end
    end
  end
endmodule
